// File: rtl/tournament_predictor.sv
// Tournament branch direction predictor: a gshare table, a two-level local
// table and a per-PC selector choosing between them. Predictions come
// straight from q_pc and the current tables. Resolved branches train all
// three tables. Global history advances speculatively on each query and is
// rebuilt from u_ghr when a mispredict comes back. After reset or flush a
// sequential walk sets every counter to weakly-not-taken and every local
// history to zero.
module tournament_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6,
  parameter int BHT_BITS   = 6,
  parameter int LHR_BITS   = 6,
  parameter int CNT_BITS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic [1:0]          mode,
  input  logic                q_valid,
  input  logic [31:0]         q_pc,
  output logic                p_taken,
  output logic                p_gshare,
  output logic                p_local,
  output logic                p_sel,
  output logic [GHR_BITS-1:0] p_ghr,
  output logic                busy,
  input  logic                u_valid,
  input  logic [31:0]         u_pc,
  input  logic                u_taken,
  input  logic                u_mispredict,
  input  logic [GHR_BITS-1:0] u_ghr,
  input  logic                u_gpred,
  input  logic                u_lpred
);

  localparam int TBL_N = 1 << INDEX_BITS;
  localparam int BHT_N = 1 << BHT_BITS;
  localparam logic [CNT_BITS-1:0]   WEAK     = CNT_BITS'((1 << (CNT_BITS-1)) - 1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX  = '1;
  localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;

  logic [CNT_BITS-1:0]   gsh_q [TBL_N];
  logic [CNT_BITS-1:0]   loc_q [TBL_N];
  logic [CNT_BITS-1:0]   sel_q [TBL_N];
  logic [LHR_BITS-1:0]   bht_q [BHT_N];

  // One saturating step of a CNT_BITS counter toward up/down; never wraps.
  function automatic logic [CNT_BITS-1:0] sat_step(input logic [CNT_BITS-1:0] c,
                                                   input logic up);
    if (up) return (c == CNT_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic run, init_wr, bht_init_wr, upd;
  assign run         = (state_q == S_RUN);
  assign busy        = !run;
  assign init_wr     = en && !run;
  assign bht_init_wr = init_wr && (int'(idx_q) < BHT_N);
  // A flush in the same cycle drops the update.
  assign upd         = en && run && u_valid && !flush;

  // Query-side indices.
  logic [INDEX_BITS-1:0] q_pcw, q_gidx, q_lidx;
  logic [BHT_BITS-1:0]   q_bidx;
  assign q_pcw  = q_pc[INDEX_BITS+1:2];
  assign q_gidx = q_pcw ^ INDEX_BITS'(ghr_q);
  assign q_bidx = q_pc[BHT_BITS+1:2];
  assign q_lidx = q_pcw ^ INDEX_BITS'(bht_q[q_bidx]);

  // Update-side indices; the local index uses the history before this update.
  logic [INDEX_BITS-1:0] u_pcw, u_gidx, u_lidx;
  logic [BHT_BITS-1:0]   u_bidx;
  assign u_pcw  = u_pc[INDEX_BITS+1:2];
  assign u_gidx = u_pcw ^ INDEX_BITS'(u_ghr);
  assign u_bidx = u_pc[BHT_BITS+1:2];
  assign u_lidx = u_pcw ^ INDEX_BITS'(bht_q[u_bidx]);

  // PC bits outside the word index never reach the tables.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{q_pc[31:INDEX_BITS+2], q_pc[1:0],
                            u_pc[31:INDEX_BITS+2], u_pc[1:0]};

  // Combinational prediction; all outputs held at zero while the walk runs.
  always_comb begin
    p_gshare = 1'b0;
    p_local  = 1'b0;
    p_sel    = 1'b0;
    p_taken  = 1'b0;
    p_ghr    = '0;
    if (run) begin
      p_gshare = gsh_q[q_gidx][CNT_BITS-1];
      p_local  = loc_q[q_lidx][CNT_BITS-1];
      p_sel    = sel_q[q_pcw][CNT_BITS-1];
      p_ghr    = ghr_q;
      case (mode)
        2'b00:   p_taken = p_sel ? p_local : p_gshare;
        2'b01:   p_taken = p_gshare;
        2'b10:   p_taken = p_local;
        default: p_taken = 1'b0;
      endcase
    end
  end

  // Control registers: FSM state, walk index and global history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ghr_q   <= ghr_d;
    end
  end

  // Next state: walk the tables, then track history; restore beats query shift.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ghr_d   = ghr_q;
    if (en) begin
      if (!run) begin
        if (flush) begin
          idx_d = '0;
          ghr_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = S_RUN;
        end
      end else if (flush) begin
        state_d = S_INIT;
        idx_d   = '0;
        ghr_d   = '0;
      end else if (u_valid && u_mispredict) begin
        ghr_d = {u_ghr[GHR_BITS-2:0], u_taken};
      end else if (q_valid) begin
        ghr_d = {ghr_q[GHR_BITS-2:0], p_taken};
      end
    end
  end

  // Gshare counters: cleared by the walk, trained by resolved branches.
  always_ff @(posedge clk) begin
    if (init_wr)  gsh_q[idx_q]  <= WEAK;
    else if (upd) gsh_q[u_gidx] <= sat_step(gsh_q[u_gidx], u_taken);
  end

  // Local counters, indexed through the pre-update local history.
  always_ff @(posedge clk) begin
    if (init_wr)  loc_q[idx_q]  <= WEAK;
    else if (upd) loc_q[u_lidx] <= sat_step(loc_q[u_lidx], u_taken);
  end

  // Selector moves toward whichever component was right when they disagreed.
  always_ff @(posedge clk) begin
    if (init_wr)
      sel_q[idx_q] <= WEAK;
    else if (upd && (u_gpred != u_lpred))
      sel_q[u_pcw] <= sat_step(sel_q[u_pcw], u_lpred == u_taken);
  end

  // Local history table: zeroed by the walk, shifted by each resolved branch.
  always_ff @(posedge clk) begin
    if (bht_init_wr)
      bht_q[idx_q[BHT_BITS-1:0]] <= '0;
    else if (upd)
      bht_q[u_bidx] <= {bht_q[u_bidx][LHR_BITS-2:0], u_taken};
  end

endmodule

// File: tb/tb_tournament_predictor.sv
// Bench for tournament_predictor: directed scenarios followed by a random
// phase, every cycle compared against a table-level model of the predictor.
module tb_tournament_predictor;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        reset, en, flush, q_valid, u_valid, u_taken, u_mispredict, u_gpred, u_lpred;
  logic [1:0]  mode;
  logic [31:0] q_pc, u_pc;
  logic [5:0]  u_ghr;
  logic        p_taken, p_gshare, p_local, p_sel, busy;
  logic [5:0]  p_ghr;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  tournament_predictor dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .mode(mode),
    .q_valid(q_valid), .q_pc(q_pc),
    .p_taken(p_taken), .p_gshare(p_gshare), .p_local(p_local), .p_sel(p_sel),
    .p_ghr(p_ghr), .busy(busy),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_mispredict(u_mispredict),
    .u_ghr(u_ghr), .u_gpred(u_gpred), .u_lpred(u_lpred)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer tables, counters 0..3, history as an int.
  int mg[N], ml[N], ms[N], mb[N];
  int m_ghr, m_left;
  bit m_run;

  function automatic void m_init();
    for (int i = 0; i < N; i++) begin
      mg[i] = 1; ml[i] = 1; ms[i] = 1; mb[i] = 0;
    end
    m_ghr = 0; m_left = N; m_run = 0;
  endfunction

  function automatic int widx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int sat(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic bit e_g(input logic [31:0] pc);
    return m_run && (mg[widx(pc) ^ m_ghr] >= 2);
  endfunction

  function automatic bit e_l(input logic [31:0] pc);
    return m_run && (ml[widx(pc) ^ mb[widx(pc)]] >= 2);
  endfunction

  function automatic bit e_s(input logic [31:0] pc);
    return m_run && (ms[widx(pc)] >= 2);
  endfunction

  function automatic bit e_t(input logic [31:0] pc);
    if (!m_run) return 1'b0;
    case (mode)
      2'd0:    return e_s(pc) ? e_l(pc) : e_g(pc);
      2'd1:    return e_g(pc);
      2'd2:    return e_l(pc);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".busy"},     32'(busy),     32'(!m_run));
    chk({tag, ".p_gshare"}, 32'(p_gshare), 32'(e_g(q_pc)));
    chk({tag, ".p_local"},  32'(p_local),  32'(e_l(q_pc)));
    chk({tag, ".p_sel"},    32'(p_sel),    32'(e_s(q_pc)));
    chk({tag, ".p_taken"},  32'(p_taken),  32'(e_t(q_pc)));
    chk({tag, ".p_ghr"},    32'(p_ghr),    32'(m_run ? m_ghr : 0));
  endtask

  // Advance one clock; the model steps from the inputs held across the edge.
  task automatic tick();
    bit t;
    int w, li;
    @(posedge clk);
    #1;
    t = e_t(q_pc);
    if (reset) begin
      m_init();
    end else if (en) begin
      if (!m_run) begin
        if (flush) m_left = N;
        else begin
          m_left--;
          if (m_left == 0) m_run = 1;
        end
      end else if (flush) begin
        m_init();
      end else begin
        if (u_valid) begin
          w  = widx(u_pc);
          li = w ^ mb[w];
          mg[w ^ int'(u_ghr)] = sat(mg[w ^ int'(u_ghr)], u_taken);
          ml[li] = sat(ml[li], u_taken);
          if (u_gpred != u_lpred) ms[w] = sat(ms[w], u_lpred == u_taken);
          mb[w] = ((mb[w] << 1) | int'(u_taken)) % N;
        end
        if (u_valid && u_mispredict) m_ghr = ((int'(u_ghr) << 1) | int'(u_taken)) % N;
        else if (q_valid)            m_ghr = ((m_ghr << 1) | int'(t)) % N;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_init();
    check_all("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 300) begin
      check_all("init");
      tick();
      cnt++;
    end
  endtask

  task automatic peek(input logic [31:0] pc);
    q_pc = pc;
    q_valid = 1'b0;
    check_all("peek");
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [5:0] gh,
                     input bit gp, input bit lp);
    u_valid = 1'b1; u_pc = pc; u_taken = tk; u_ghr = gh;
    u_gpred = gp; u_lpred = lp; u_mispredict = 1'b0;
    check_all("upd");
    tick();
    u_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b1; flush = 1'b0; mode = 2'b00;
    q_valid = 1'b0; q_pc = '0;
    u_valid = 1'b0; u_pc = '0; u_taken = 1'b0; u_mispredict = 1'b0;
    u_ghr = '0; u_gpred = 1'b0; u_lpred = 1'b0;
    m_init();
    #2;

    // Reset state and walk length.
    do_reset();
    chk("rst_busy", 32'(busy), 32'd1);
    count_busy(n);
    chk("busy_len", 32'(n), 32'd64);
    peek(32'h40);
    chk("q40_taken", 32'(p_taken), 32'd0);
    chk("q40_ghr",   32'(p_ghr),   32'd0);
    tick();

    // en held low for 10 cycles in the middle of the walk.
    do_reset();
    n = 0;
    while (busy && n < 300) begin
      en = !(n >= 20 && n < 30);
      check_all("pause");
      tick();
      n++;
    end
    en = 1'b1;
    chk("busy_len_pause", 32'(n), 32'd74);

    // Gshare training at 0x40 with ghr 0.
    upd(32'h40, 1'b1, 6'd0, 1'b0, 1'b0);
    upd(32'h40, 1'b1, 6'd0, 1'b0, 1'b0);
    peek(32'h40);
    chk("gsh_trained", 32'(p_gshare), 32'd1);
    tick();

    // Saturation at 3, then down by one and by two.
    for (int i = 0; i < 5; i++) upd(32'h40, 1'b1, 6'd0, 1'b0, 1'b0);
    upd(32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    peek(32'h40);
    chk("gsh_sat_down1", 32'(p_gshare), 32'd1);
    tick();
    upd(32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    peek(32'h40);
    chk("gsh_sat_down2", 32'(p_gshare), 32'd0);
    tick();
    upd(32'h40, 1'b1, 6'd0, 1'b0, 1'b0);
    upd(32'h40, 1'b1, 6'd0, 1'b0, 1'b0);

    // History restore: six taken queries, then mispredict with a same-cycle query.
    upd(32'h40, 1'b1, 6'd1,  1'b0, 1'b0);
    upd(32'h40, 1'b1, 6'd3,  1'b0, 1'b0);
    upd(32'h40, 1'b1, 6'd7,  1'b0, 1'b0);
    upd(32'h40, 1'b1, 6'd15, 1'b0, 1'b0);
    upd(32'h40, 1'b1, 6'd31, 1'b0, 1'b0);
    mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      q_pc = 32'h40; q_valid = 1'b1;
      check_all("spec_q");
      chk("spec_q_taken", 32'(p_taken), 32'd1);
      tick();
    end
    peek(32'h40);
    chk("ghr_all_ones", 32'(p_ghr), 32'h3f);
    q_valid = 1'b1;
    u_valid = 1'b1; u_pc = 32'h40; u_mispredict = 1'b1; u_ghr = 6'b000011; u_taken = 1'b1;
    u_gpred = 1'b0; u_lpred = 1'b0;
    check_all("restore");
    tick();
    u_valid = 1'b0; u_mispredict = 1'b0;
    peek(32'h40);
    chk("ghr_restored", 32'(p_ghr), 32'b000111);
    tick();

    // Selector training on 0x80.
    mode = 2'b00;
    peek(32'h80);
    chk("sel_init", 32'(p_sel), 32'd0);
    tick();
    upd(32'h80, 1'b1, 6'd0, 1'b0, 1'b1);
    peek(32'h80);
    chk("sel_up", 32'(p_sel), 32'd1);
    tick();
    upd(32'h80, 1'b1, 6'd0, 1'b1, 1'b1);
    peek(32'h80);
    chk("sel_agree_hold", 32'(p_sel), 32'd1);
    tick();
    upd(32'h80, 1'b1, 6'd0, 1'b1, 1'b0);
    peek(32'h80);
    chk("sel_down", 32'(p_sel), 32'd0);
    tick();

    // Static not-taken mode.
    mode = 2'b11;
    peek(32'h40);
    chk("static_taken", 32'(p_taken), 32'd0);
    chk("static_gsh",   32'(p_gshare), 32'd1);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      en           = ($urandom_range(0, 15) != 0);
      flush        = ($urandom_range(0, 299) == 0);
      mode         = 2'($urandom_range(0, 3));
      q_valid      = 1'($urandom_range(0, 1));
      q_pc         = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
      u_valid      = 1'($urandom_range(0, 1));
      u_pc         = ($urandom_range(0, 3) == 0) ? q_pc :
                     (($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2));
      u_taken      = 1'($urandom_range(0, 1));
      u_mispredict = ($urandom_range(0, 3) == 0);
      u_ghr        = 6'($urandom());
      u_gpred      = 1'($urandom_range(0, 1));
      u_lpred      = 1'($urandom_range(0, 1));
      check_all("rnd");
      tick();
    end
    en = 1'b1; flush = 1'b0; mode = 2'b00; q_valid = 1'b0;
    u_valid = 1'b0; u_mispredict = 1'b0;

    // Flush: walk again, then every entry reads back weakly not-taken.
    flush = 1'b1;
    check_all("flush");
    tick();
    flush = 1'b0;
    count_busy(n);
    chk("flush_busy_len", 32'(n), 32'd64);
    for (int i = 0; i < N; i++) begin
      peek(32'(i) << 2);
      chk("clr_gsh", 32'(p_gshare), 32'd0);
      chk("clr_loc", 32'(p_local),  32'd0);
      chk("clr_sel", 32'(p_sel),    32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
